// File: rtl/csr_access_arb_pkg.sv
// -----------------------------------------------------------------------------
// csr_access_arb_pkg
// Shared definitions for the machine-CSR access arbiter:
//   - CSR operation encodings carried on core_op / dbg_op
//   - access sequencer state encoding
//   - requester identifiers used by the round-robin arbiter
//   - default CSR address / data widths
// -----------------------------------------------------------------------------
package csr_access_arb_pkg;

  localparam int CSR_AW_DEFAULT     = 12;
  localparam int DATA_WIDTH_DEFAULT = 32;

  localparam logic [1:0] CSR_OP_READ  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLR   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } csr_state_e;

  // Requester identity; also the bit index of that requester in req/grant vectors.
  localparam logic GRANT_CORE = 1'b0;
  localparam logic GRANT_DBG  = 1'b1;

  // Every op except a plain read needs a write phase.
  function automatic logic csrOpWrites(input logic [1:0] op);
    return op != CSR_OP_READ;
  endfunction

endpackage

// File: rtl/csr_access_arb_rr_arb2.sv
// -----------------------------------------------------------------------------
// csr_rr_arb2
// Two-requester round-robin arbiter. When both requesters are pending the one
// that was not granted last wins; a single pending requester always wins.
// Grants are only issued while grant_en_i is high, and last_grant only moves
// when a grant is actually issued.
// Ports:
//   cpu_clk, cpu_rstn : clock, asynchronous active-low reset
//   req_i[1:0]        : bit 0 = core, bit 1 = debug
//   grant_en_i        : arbiter may grant this cycle
//   grant_o[1:0]      : one-hot grant (zero when nothing granted)
// -----------------------------------------------------------------------------
module csr_rr_arb2
  import csr_access_arb_pkg::*;
(
  input  logic       cpu_clk,
  input  logic       cpu_rstn,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic [1:0] grant_o
);

  logic last_grant_q, last_grant_d;

  // Pick the winner and remember who it was.
  always_comb begin
    grant_o      = 2'b00;
    last_grant_d = last_grant_q;
    if (grant_en_i) begin
      if (req_i == 2'b11) begin
        grant_o = (last_grant_q == GRANT_DBG) ? 2'b01 : 2'b10;
      end else begin
        grant_o = req_i;
      end
      if (|req_i) begin
        last_grant_d = grant_o[1];
      end
    end
  end

  // After reset the core counts as last granted, so a simultaneous first
  // request from both sides goes to the debug port.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      last_grant_q <= GRANT_CORE;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/csr_access_arb.sv
// -----------------------------------------------------------------------------
// csr_access_arb
// Sequences machine-CSR accesses as a read phase (RD) optionally followed by a
// write phase (WR) on the CSR block interface, then returns the old value and
// an illegal-access flag to the granted requester in a one-cycle DONE pulse.
//   IDLE -> RD -> (WR) -> DONE -> IDLE
// Build option:
//   KRV_CSR_DBG_PORT_EN defined   : debug port active, round-robin with core
//   KRV_CSR_DBG_PORT_EN undefined : core is the only requester, dbg_* ignored,
//                                   dbg_done / dbg_rdata / dbg_err tied to 0
// Ports:
//   cpu_clk, cpu_rstn                          : clock, async active-low reset
//   core_req/addr/op/wdata -> core_done/rdata/err : core request / response
//   dbg_req/addr/op/wdata  -> dbg_done/rdata/err  : debug request / response
//   trap_busy                                  : blocks new grants in IDLE
//   csr_addr, mcsr_rd, mcsr_wr, valid_mcsr_rd, valid_mcsr_wr,
//   mcsr_set, mcsr_clr, write_data             : to the CSR block
//   read_data, csr_illegal_access              : from the CSR block
//   busy                                       : sequencer not in IDLE
// -----------------------------------------------------------------------------
module csr_access_arb
  import csr_access_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int CSR_AW     = CSR_AW_DEFAULT
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic                  core_req,
  input  logic [CSR_AW-1:0]     core_addr,
  input  logic [1:0]            core_op,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_done,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_err,
  input  logic                  dbg_req,
  input  logic [CSR_AW-1:0]     dbg_addr,
  input  logic [1:0]            dbg_op,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic                  dbg_done,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  input  logic                  trap_busy,
  output logic [CSR_AW-1:0]     csr_addr,
  output logic                  mcsr_rd,
  output logic                  mcsr_wr,
  output logic                  valid_mcsr_rd,
  output logic                  valid_mcsr_wr,
  output logic                  mcsr_set,
  output logic                  mcsr_clr,
  output logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic                  csr_illegal_access,
  output logic                  busy
);

  csr_state_e            state_q, state_d;
  logic                  sel_q, sel_d;
  logic [CSR_AW-1:0]     addr_q, addr_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  grantEn;
  logic                  grantAny;
  logic                  grantDbg;
  logic [CSR_AW-1:0]     reqAddr;
  logic [1:0]            reqOp;
  logic [DATA_WIDTH-1:0] reqWdata;

  // trap_busy only holds off new grants; in-flight transactions ignore it.
  assign grantEn = (state_q == ST_IDLE) && !trap_busy;

`ifdef KRV_CSR_DBG_PORT_EN
  logic [1:0] grantVec;

  csr_rr_arb2 u_rr_arb (
    .cpu_clk    (cpu_clk),
    .cpu_rstn   (cpu_rstn),
    .req_i      ({dbg_req, core_req}),
    .grant_en_i (grantEn),
    .grant_o    (grantVec)
  );

  assign grantAny = |grantVec;
  assign grantDbg = grantVec[1];
  assign reqAddr  = grantDbg ? dbg_addr  : core_addr;
  assign reqOp    = grantDbg ? dbg_op    : core_op;
  assign reqWdata = grantDbg ? dbg_wdata : core_wdata;
`else
  logic unused_dbg;

  assign unused_dbg = ^{dbg_req, dbg_addr, dbg_op, dbg_wdata};
  assign grantAny   = grantEn && core_req;
  assign grantDbg   = 1'b0;
  assign reqAddr    = core_addr;
  assign reqOp      = core_op;
  assign reqWdata   = core_wdata;
`endif

  assign busy = (state_q != ST_IDLE);

  // Next-state and output decode. All CSR-side and response outputs default to
  // zero so they are only non-zero in their own phase.
  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    addr_d        = addr_q;
    op_d          = op_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    err_d         = err_q;
    csr_addr      = '0;
    mcsr_rd       = 1'b0;
    mcsr_wr       = 1'b0;
    valid_mcsr_rd = 1'b0;
    valid_mcsr_wr = 1'b0;
    mcsr_set      = 1'b0;
    mcsr_clr      = 1'b0;
    write_data    = '0;
    core_done     = 1'b0;
    core_rdata    = '0;
    core_err      = 1'b0;
    dbg_done      = 1'b0;
    dbg_rdata     = '0;
    dbg_err       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grantAny) begin
          sel_d   = grantDbg;
          addr_d  = reqAddr;
          op_d    = reqOp;
          wdata_d = reqWdata;
          state_d = ST_RD;
        end
      end

      // mcsr_wr is raised already in the read phase so the CSR block can flag
      // a write to a read-only register before any write is committed.
      ST_RD: begin
        csr_addr      = addr_q;
        mcsr_rd       = 1'b1;
        valid_mcsr_rd = 1'b1;
        mcsr_wr       = csrOpWrites(op_q);
        rdata_d       = csr_illegal_access ? '0 : read_data;
        err_d         = csr_illegal_access;
        state_d       = (csrOpWrites(op_q) && !csr_illegal_access) ? ST_WR : ST_DONE;
      end

      ST_WR: begin
        csr_addr      = addr_q;
        mcsr_wr       = 1'b1;
        valid_mcsr_wr = 1'b1;
        write_data    = wdata_q;
        mcsr_set      = (op_q == CSR_OP_SET);
        mcsr_clr      = (op_q == CSR_OP_CLR);
        state_d       = ST_DONE;
      end

      ST_DONE: begin
        if (sel_q == GRANT_DBG) begin
`ifdef KRV_CSR_DBG_PORT_EN
          dbg_done  = 1'b1;
          dbg_rdata = rdata_q;
          dbg_err   = err_q;
`endif
        end else begin
          core_done  = 1'b1;
          core_rdata = rdata_q;
          core_err   = err_q;
        end
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and transaction registers; reset drops any transaction in flight.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= ST_IDLE;
      sel_q   <= GRANT_CORE;
      addr_q  <= '0;
      op_q    <= CSR_OP_READ;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/csr_access_arb.md
Name: csr_access_arb

Overview:
- Sequences every machine-CSR access as a two-phase read/modify/write transaction on the machine CSR block's access interface.
- Arbitrates between two requesters:
  - the core decode stage (CSR instructions);
  - the debug port (external host inspection and patching of CSRs).
- Returns the old CSR value and an illegal-access flag to whichever requester was granted.
- Sits between dec, the debug module and the machine CSR block.

Parameters:
- DATA_WIDTH, 32, CSR data width.
- CSR_AW, 12, CSR address width.

Ports:
- cpu_clk  in  1  cpu clock
- cpu_rstn  in  1  asynchronous active-low reset
- core_req  in  1  core request; held until core_done
- core_addr  in  CSR_AW  core CSR address
- core_op  in  2  00 read, 01 write, 10 set, 11 clear
- core_wdata  in  DATA_WIDTH  core write/mask data
- core_done  out  1  one-cycle completion pulse
- core_rdata  out  DATA_WIDTH  old CSR value, valid with core_done
- core_err  out  1  illegal access, valid with core_done
- dbg_req / dbg_addr / dbg_op / dbg_wdata  in  1 / CSR_AW / 2 / DATA_WIDTH  debug request, same rules as core
- dbg_done / dbg_rdata / dbg_err  out  1 / DATA_WIDTH / 1  debug response
- trap_busy  in  1  valid_interrupt or mret this cycle; blocks new grants
- csr_addr  out  CSR_AW  to CSR block
- mcsr_rd, mcsr_wr  out  1  access-type strobes for the legality check
- valid_mcsr_rd, valid_mcsr_wr  out  1  committed read / committed write
- mcsr_set, mcsr_clr  out  1  write qualifiers
- write_data  out  DATA_WIDTH  to CSR block
- read_data  in  DATA_WIDTH  from CSR block
- csr_illegal_access  in  1  from CSR block, combinational on csr_addr/strobes
- busy  out  1  state != IDLE

Behaviour:
- Reset: cpu_rstn asynchronous, active-low; clock cpu_clk.
  - State IDLE; all outputs 0; last_grant = core.
- States: IDLE -> RD -> (WR) -> DONE -> IDLE.
- IDLE:
  - Grant when trap_busy = 0 and any req = 1.
  - If both requesters are pending: round-robin, i.e. grant the one not in last_grant.
  - Latch sel, addr, op, wdata into internal registers; update last_grant; go to RD.
- RD, one cycle:
  - csr_addr = latched addr; mcsr_rd = 1; valid_mcsr_rd = 1.
  - mcsr_wr = (op != 00), so a write to a read-only CSR is flagged by the CSR block.
  - Capture read_data into rdata_q and csr_illegal_access into err_q.
  - Next state: WR if op != 00 and illegal = 0; otherwise DONE.
- WR, one cycle:
  - csr_addr held; mcsr_wr = 1; valid_mcsr_wr = 1; write_data = wdata.
  - mcsr_set = (op == 10); mcsr_clr = (op == 11).
  - Next state DONE.
- DONE, one cycle:
  - Pulse the done of the selected requester, with rdata = rdata_q and err = err_q.
  - Unselected requester outputs stay 0. Go to IDLE.
- Latency from a req seen in IDLE (cycle 0): read completes with done at cycle 2; write/set/clear with done at cycle 3. Back-to-back throughput is one transaction per 3 or 4 cycles.
- Illegal access: no valid_mcsr_wr is ever issued, so CSR state is unchanged; err = 1 and rdata = 0.
- trap_busy only blocks the IDLE grant. A transaction already in RD or WR completes.
- Requester dropping req mid-transaction: the transaction still completes and done still pulses.
- Outside RD and WR, every CSR-side output is 0.
- Reset mid-transaction: return to IDLE immediately; no done is issued.

Optional Feature:
- Macro: KRV_CSR_DBG_PORT_EN.
- Defined: debug port and round-robin arbitration as above.
- Undefined:
  - dbg_* inputs are ignored;
  - dbg_done, dbg_rdata and dbg_err are tied to 0;
  - the core is the sole requester and last_grant logic is removed.
  - Timing is otherwise identical.

Decomposition:
- Shared package / core_defines.vh: CSR_OP_READ/WRITE/SET/CLR encodings; state encodings (IDLE = 0, RD = 1, WR = 2, DONE = 3); CSR_AW.
- One natural sub-module, csr_rr_arb2: two-requester round-robin arbiter (req[1:0], grant_en, last_grant register, one-hot grant out).

Test Plan:
- Core read of mstatus (0x300) with MIE = 1:
  - core_done at cycle 2, core_rdata = 0x8, core_err = 0;
  - valid_mcsr_wr never asserted.
- Core write of mtvec (0x305), wdata 0x0000_1001:
  - WR cycle shows mcsr_wr = 1, set = clr = 0, write_data = 0x1001;
  - done at cycle 3, rdata = previous mtvec value.
- Core set of mie (0x304), wdata 0x800, then clear with the same mask:
  - first transaction: mcsr_set = 1 in WR; second: mcsr_clr = 1;
  - the second transaction's rdata shows bit 11 = 1.
- Debug write to mvendorid (0xF11) or to unmapped 0x7C0:
  - dbg_err = 1, dbg_rdata = 0, no valid_mcsr_wr;
  - state returns to IDLE after DONE.
- core_req and dbg_req high together and held:
  - grants alternate core, dbg, core…, each getting its own done;
  - trap_busy pulsed in IDLE delays the next grant by exactly its duration.
- Reset asserted during WR:
  - all outputs 0 asynchronously;
  - neither done pulses after release.
